sram_port_ctrl: RTL and testbench

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_port_ctrl.sv | 143 ++++++++++++++
 tb/tb_sram_port_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// SRAM port controller: fills the array with INIT_VAL after reset or on request,
// then serves one write and one pipelined read per cycle with write-first collisions.
module sram_port_ctrl #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 14,
    parameter int                 RD_LAT   = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              init_req_i,
    input  logic              set_wr_en,
    input  logic [ADDR_W-1:0] set_wr_addr,
    input  logic [DATA_W-1:0] set_wr_data,
    input  logic              set_rd_en,
    input  logic [ADDR_W-1:0] set_rd_addr,
    output logic [DATA_W-1:0] set_rd_data,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // state   | meaning
    // ST_INIT | writing INIT_VAL to address cnt_q, user strobes dropped
    // ST_IDLE | serving user writes and reads
    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic                rd_vld1_q, rd_vld1_d;
    logic [DATA_W-1:0]   rd_dat1_q, rd_dat1_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = set_wr_addr;
        mem_wdata = set_wr_data;
        rd_acc    = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Held reset must not keep rewriting address 0.
                mem_we    = ~reset_i;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                drop_d    = set_wr_en | set_rd_en;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                mem_we = set_wr_en;
                rd_acc = set_rd_en;
                if (init_req_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_word = mem[set_rd_addr];
        if (set_wr_en && (set_wr_addr == set_rd_addr)) begin
            rd_word = set_wr_data;
        end
        rd_vld1_d = rd_acc;
        rd_dat1_d = rd_acc ? rd_word : rd_dat1_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            rd_vld1_q <= 1'b0;
            rd_dat1_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            rd_vld1_q <= rd_vld1_d;
            rd_dat1_q <= rd_dat1_d;
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd_vld2_q, rd_vld2_d;
            logic [DATA_W-1:0] rd_dat2_q, rd_dat2_d;

            always_comb begin
                rd_vld2_d = rd_vld1_q;
                rd_dat2_d = rd_vld1_q ? rd_dat1_q : rd_dat2_q;
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    rd_vld2_q <= 1'b0;
                    rd_dat2_q <= '0;
                end else begin
                    rd_vld2_q <= rd_vld2_d;
                    rd_dat2_q <= rd_dat2_d;
                end
            end

            assign rd_valid_o  = rd_vld2_q;
            assign set_rd_data = rd_dat2_q;
        end else begin : g_lat1
            assign rd_valid_o  = rd_vld1_q;
            assign set_rd_data = rd_dat1_q;
        end
    endgenerate

    assign busy_o = (state_q == ST_INIT);
    assign drop_o = drop_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: one instance per read latency on shared stimulus,
// checked every cycle against a memory/queue model plus literal expectations.
module tb_sram_port_ctrl;

    localparam int          DW    = 16;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] IV    = 16'hA5A5;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          init_req_i = 1'b0;
    logic          set_wr_en = 1'b0;
    logic [AW-1:0] set_wr_addr = '0;
    logic [DW-1:0] set_wr_data = '0;
    logic          set_rd_en = 1'b0;
    logic [AW-1:0] set_rd_addr = '0;

    logic [DW-1:0] rd_data_1, rd_data_2;
    logic          rd_valid_1, rd_valid_2, busy_1, busy_2, drop_1, drop_2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL(IV)) u_lat1 (
        .clk_i(clk), .reset_i(reset_i), .init_req_i(init_req_i),
        .set_wr_en(set_wr_en), .set_wr_addr(set_wr_addr), .set_wr_data(set_wr_data),
        .set_rd_en(set_rd_en), .set_rd_addr(set_rd_addr), .set_rd_data(rd_data_1),
        .rd_valid_o(rd_valid_1), .busy_o(busy_1), .drop_o(drop_1)
    );

    sram_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL(IV)) u_lat2 (
        .clk_i(clk), .reset_i(reset_i), .init_req_i(init_req_i),
        .set_wr_en(set_wr_en), .set_wr_addr(set_wr_addr), .set_wr_data(set_wr_data),
        .set_rd_en(set_rd_en), .set_rd_addr(set_rd_addr), .set_rd_data(rd_data_2),
        .rd_valid_o(rd_valid_2), .busy_o(busy_2), .drop_o(drop_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: an array, a count of init cycles still owed, and per-latency queues
    // of read results tagged with the edge index at which they must appear.
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    rd_t         q1[$];
    rd_t         q2[$];
    logic [15:0] mem_m [DEPTH];
    int          init_left = DEPTH;
    int          ecnt = 0;
    logic        exp_busy = 1'b1, exp_drop = 1'b0, exp_v1 = 1'b0, exp_v2 = 1'b0;
    logic [15:0] exp_d1 = '0, exp_d2 = '0;

    task automatic model_step();
        rd_t r;
        ecnt++;
        if (reset_i) begin
            init_left = DEPTH;
            q1.delete();
            q2.delete();
            exp_busy = 1'b1;
            exp_drop = 1'b0;
            exp_v1 = 1'b0;
            exp_v2 = 1'b0;
            exp_d1 = '0;
            exp_d2 = '0;
        end else begin
            if (init_left > 0) begin
                mem_m[DEPTH - init_left] = IV;
                init_left--;
                exp_drop = set_wr_en || set_rd_en;
            end else begin
                exp_drop = 1'b0;
                if (set_rd_en) begin
                    r.d = (set_wr_en && set_wr_addr == set_rd_addr) ? set_wr_data : mem_m[set_rd_addr];
                    r.due = ecnt;
                    q1.push_back(r);
                    r.due = ecnt + 1;
                    q2.push_back(r);
                end
                if (set_wr_en) mem_m[set_wr_addr] = set_wr_data;
                if (init_req_i) init_left = DEPTH;
            end
            exp_busy = (init_left > 0);
            exp_v1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == ecnt) begin
                exp_v1 = 1'b1;
                exp_d1 = q1[0].d;
                void'(q1.pop_front());
            end
            exp_v2 = 1'b0;
            if (q2.size() > 0 && q2[0].due == ecnt) begin
                exp_v2 = 1'b1;
                exp_d2 = q2[0].d;
                void'(q2.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("m_busy_l1", busy_1, exp_busy);
        check("m_busy_l2", busy_2, exp_busy);
        check("m_drop_l1", drop_1, exp_drop);
        check("m_drop_l2", drop_2, exp_drop);
        check("m_valid_l1", rd_valid_1, exp_v1);
        check("m_valid_l2", rd_valid_2, exp_v2);
        check("m_data_l1", rd_data_1, exp_d1);
        check("m_data_l2", rd_data_2, exp_d2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_wr_en = 1'b1;
        set_wr_addr = a;
        set_wr_data = d;
        @(negedge clk);
        set_wr_en = 1'b0;
    endtask

    // Issues a read (plus whatever write the caller set up) and checks both latencies.
    task automatic rd_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        set_rd_en = 1'b1;
        set_rd_addr = a;
        @(posedge clk);
        #1;
        set_rd_en = 1'b0;
        set_wr_en = 1'b0;
        check({name, "_v_l1"}, rd_valid_1, 1);
        check({name, "_d_l1"}, rd_data_1, exp);
        check({name, "_early_l2"}, rd_valid_2, 0);
        @(posedge clk);
        #1;
        check({name, "_v_l2"}, rd_valid_2, 1);
        check({name, "_d_l2"}, rd_data_2, exp);
        check({name, "_once_l1"}, rd_valid_1, 0);
        @(negedge clk);
    endtask

    // Counts edges until busy drops; optionally pokes user strobes mid-init.
    task automatic count_busy(output int n, input bit inject);
        set_wr_en = 1'b0;
        set_rd_en = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (inject) begin
                if (k == 3) begin
                    set_wr_en = 1'b1;
                    set_wr_addr = 4'd2;
                    set_wr_data = 16'hFFFF;
                end else if (k == 4) begin
                    set_wr_en = 1'b0;
                    check("drop_wr", drop_1, 1);
                end else if (k == 5) begin
                    check("drop_wr_single", drop_1, 0);
                end else if (k == 6) begin
                    set_wr_en = 1'b1;
                    set_wr_addr = 4'd5;
                    set_wr_data = 16'h0BAD;
                    set_rd_en = 1'b1;
                    set_rd_addr = 4'd2;
                end else if (k == 7) begin
                    set_wr_en = 1'b0;
                    set_rd_en = 1'b0;
                    check("drop_both", drop_1, 1);
                    check("drop_both_no_rd", rd_valid_1, 0);
                end else if (k == 8) begin
                    check("drop_both_single", drop_1, 0);
                end
            end
            if (!busy_1) break;
        end
        @(negedge clk);
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy_1, 1);
        check("rst_valid", rd_valid_2, 0);
        check("rst_data", rd_data_2, 0);
        reset_i = 1'b0;
        count_busy(n, 1'b1);
        check("pwr_busy_cycles", n, 16);

        for (int i = 0; i < DEPTH; i++) begin
            set_rd_en = 1'b1;
            set_rd_addr = AW'(i);
            @(negedge clk);
        end
        set_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rd_lit(4'd0, 16'hA5A5, "pwr_a0");
        rd_lit(4'd15, 16'hA5A5, "pwr_a15");
        rd_lit(4'd2, 16'hA5A5, "drop_a2");
        rd_lit(4'd5, 16'hA5A5, "drop_a5");

        wr(4'd3, 16'h1234);
        rd_lit(4'd3, 16'h1234, "lat");

        wr(4'd7, 16'h0001);
        set_wr_en = 1'b1;
        set_wr_addr = 4'd7;
        set_wr_data = 16'hBEEF;
        rd_lit(4'd7, 16'hBEEF, "coll");
        rd_lit(4'd7, 16'hBEEF, "coll_after");

        set_rd_en = 1'b1;
        set_rd_addr = 4'd5;
        @(posedge clk);
        #1;
        set_rd_en = 1'b0;
        set_wr_en = 1'b1;
        set_wr_addr = 4'd5;
        set_wr_data = 16'h5555;
        check("war_d_l1", rd_data_1, 16'hA5A5);
        @(posedge clk);
        #1;
        set_wr_en = 1'b0;
        check("war_v_l2", rd_valid_2, 1);
        check("war_d_l2", rd_data_2, 16'hA5A5);
        @(negedge clk);
        rd_lit(4'd5, 16'h5555, "war_after");

        init_req_i = 1'b1;
        set_wr_en = 1'b1;
        set_wr_addr = 4'd10;
        set_wr_data = 16'h7777;
        @(posedge clk);
        #1;
        init_req_i = 1'b0;
        set_wr_en = 1'b0;
        check("reinit_rise", busy_1, 1);
        count_busy(n, 1'b0);
        check("reinit_busy_cycles", n, 16);
        rd_lit(4'd3, 16'hA5A5, "reinit_a3");
        rd_lit(4'd7, 16'hA5A5, "reinit_a7");
        rd_lit(4'd10, 16'hA5A5, "reinit_a10");

        wr(4'd0, 16'h1111);
        init_req_i = 1'b1;
        @(negedge clk);
        init_req_i = 1'b0;
        repeat (9) @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        count_busy(n, 1'b0);
        check("rst_mid_init_cycles", n, 16);
        rd_lit(4'd0, 16'hA5A5, "rst_mid_init_a0");

        wr(4'd4, 16'h4444);
        set_rd_en = 1'b1;
        set_rd_addr = 4'd4;
        @(posedge clk);
        #1;
        set_rd_en = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_discard_v_l2", rd_valid_2, 0);
        check("rst_discard_d_l2", rd_data_2, 0);
        @(negedge clk);
        reset_i = 1'b0;
        count_busy(n, 1'b0);
        check("rst_mid_read_cycles", n, 16);
        rd_lit(4'd4, 16'hA5A5, "rst_mid_read_a4");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
